// File: rtl/ahb_gpio_arbiter.sv
// Two-requester AHB-Lite master front-end for the GPIO slave.
// Round-robin grant, one transfer at a time (address phase, then data phase with
// wait states), data-phase timeout, read data return.
// Optional: define AHB_GPIO_ARB_PARITY_EN to flag PARITYERR on completing reads via ERR.
module ahb_gpio_arbiter #(
  parameter logic [31:0] GPIO_BASE = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WE,
  input  logic [1:0]  DIRSEL,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic [1:0]  GNT,
  output logic [1:0]  DONE,
  output logic [15:0] RDATA,
  output logic        ERR,
  output logic        HSEL,
  output logic [1:0]  HTRANS,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA,
  input  logic        PARITYERR
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic        win_q;      // requester being served (arbitrated in IDLE)
  logic        last_q;     // requester granted most recently
  logic        cmd_we_q;
  logic        cmd_dir_q;
  logic [15:0] wdata_q;
  logic [7:0]  wait_q;
  logic [1:0]  done_q;
  logic        err_q;
  logic [15:0] rdata_q;

  logic        addr_ok;
  logic        complete;
  logic        timeout;
  logic        par_err;

  // A grant only happens if the winner still requests in the address cycle.
  assign addr_ok  = (state_q == StAddr) && REQ[win_q];
  assign complete = (state_q == StData) && HREADYOUT;
  assign timeout  = (state_q == StData) && !HREADYOUT && ((wait_q + 8'd1) == TimeoutCnt);

`ifdef AHB_GPIO_ARB_PARITY_EN
  assign par_err = complete && !cmd_we_q && PARITYERR;
  logic unused_hrdata;
  assign unused_hrdata = ^HRDATA[31:16];
`else
  assign par_err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{HRDATA[31:16], PARITYERR};
`endif

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (|REQ) state_d = StAddr;
      StAddr:  state_d = REQ[win_q] ? StData : StIdle;
      StData:  if (HREADYOUT || timeout) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Arbitration, command latch, wait counter and completion status.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      win_q     <= 1'b0;
      last_q    <= 1'b1;
      cmd_we_q  <= 1'b0;
      cmd_dir_q <= 1'b0;
      wdata_q   <= '0;
      wait_q    <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if ((state_q == StIdle) && (|REQ)) begin
        // On a tie, favour the requester not granted last.
        win_q <= (REQ == 2'b11) ? ~last_q : REQ[1];
      end
      if (addr_ok) begin
        last_q    <= win_q;
        cmd_we_q  <= WE[win_q];
        cmd_dir_q <= DIRSEL[win_q];
        wdata_q   <= win_q ? WDATA1 : WDATA0;
        wait_q    <= '0;
      end else if ((state_q == StData) && !HREADYOUT) begin
        wait_q <= wait_q + 8'd1;
      end
      done_q <= '0;
      err_q  <= 1'b0;
      if (complete || timeout) begin
        done_q <= win_q ? 2'b10 : 2'b01;
        err_q  <= timeout | par_err;
      end
      if (complete && !cmd_we_q) begin
        rdata_q <= HRDATA[15:0];
      end
    end
  end

  // Bus outputs decoded from state and the latched command.
  always_comb begin
    GNT    = '0;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = '0;
    HWRITE = 1'b0;
    HWDATA = '0;
    if (addr_ok) begin
      GNT    = win_q ? 2'b10 : 2'b01;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = GPIO_BASE + (DIRSEL[win_q] ? 32'd4 : 32'd0);
      HWRITE = WE[win_q];
    end
    if ((state_q == StData) && cmd_we_q) begin
      // Direction writes replicate bit 0 across all pins.
      HWDATA = cmd_dir_q ? (wdata_q[0] ? 32'hFFFF_FFFF : 32'h0000_0000) : {16'h0000, wdata_q};
    end
  end

  assign DONE   = done_q;
  assign ERR    = err_q;
  assign RDATA  = rdata_q;
  assign HREADY = HREADYOUT;

endmodule

// File: tb/tb_ahb_gpio_arbiter.sv
// Directed self-checking bench for ahb_gpio_arbiter.
module tb_ahb_gpio_arbiter;

  localparam int unsigned TO = 16;
  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        HCLK, HRESETn;
  logic [1:0]  REQ, WE, DIRSEL;
  logic [15:0] WDATA0, WDATA1;
  logic [1:0]  GNT, DONE;
  logic [15:0] RDATA;
  logic        ERR, HSEL, HWRITE, HREADY, HREADYOUT, PARITYERR;
  logic [1:0]  HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA;

  int n_vec = 0;
  int n_err = 0;

  // Round-robin run with both requests held from reset: cycles 0..12.
  logic [1:0] rr_gnt  [13] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                               2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
  logic [1:0] rr_done [13] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                               2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

  ahb_gpio_arbiter #(
    .GPIO_BASE (BASE),
    .TIMEOUT   (TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .REQ       (REQ),
    .WE        (WE),
    .DIRSEL    (DIRSEL),
    .WDATA0    (WDATA0),
    .WDATA1    (WDATA1),
    .GNT       (GNT),
    .DONE      (DONE),
    .RDATA     (RDATA),
    .ERR       (ERR),
    .HSEL      (HSEL),
    .HTRANS    (HTRANS),
    .HADDR     (HADDR),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .PARITYERR (PARITYERR)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Start of a cycle: just after the rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  // Mid-cycle sampling point.
  task automatic mid();
    @(negedge HCLK);
  endtask

  // One complete transfer starting in an IDLE cycle; waits >= TO means timeout.
  task automatic xfer(input bit id, input bit we, input bit dir, input logic [15:0] wd,
                      input int waits, input logic [31:0] hrd, input bit par,
                      input logic [31:0] exp_wd, input logic [15:0] exp_rd,
                      input bit exp_err);
    bit tmo;
    int nd;
    tmo = (waits >= int'(TO));
    nd  = tmo ? int'(TO) : waits + 1;
    REQ       = id ? 2'b10 : 2'b01;
    WE        = {we, we};
    DIRSEL    = {dir, dir};
    WDATA0    = wd;
    WDATA1    = wd;
    HREADYOUT = 1'b1;
    mid();
    check("gnt_idle", GNT, 2'b00);
    cyc();
    mid();
    check("gnt", GNT, id ? 2'b10 : 2'b01);
    check("hsel", HSEL, 1'b1);
    check("htrans", HTRANS, 2'b10);
    check("haddr", HADDR, dir ? 32'h4000_1004 : 32'h4000_1000);
    check("hwrite", HWRITE, we);
    cyc();
    REQ       = 2'b00;
    HRDATA    = hrd;
    PARITYERR = par;
    for (int i = 0; i < nd; i++) begin
      HREADYOUT = !tmo && (i == waits);
      mid();
      check("hwdata", HWDATA, exp_wd);
      check("done_wait", DONE, 2'b00);
      if (i == 0) begin
        check("hsel_data", HSEL, 1'b0);
        check("hready", HREADY, HREADYOUT);
      end
      cyc();
    end
    HREADYOUT = 1'b1;
    PARITYERR = 1'b0;
    mid();
    check("done", DONE, id ? 2'b10 : 2'b01);
    check("err", ERR, exp_err);
    check("rdata", RDATA, exp_rd);
    cyc();
  endtask

  initial begin
    HRESETn = 1'b0; REQ = '0; WE = '0; DIRSEL = '0; WDATA0 = '0; WDATA1 = '0;
    HREADYOUT = 1'b1; HRDATA = '0; PARITYERR = 1'b0;
    repeat (2) @(posedge HCLK);
    mid();
    check("rst_gnt", GNT, 2'b00);
    check("rst_done", DONE, 2'b00);
    check("rst_err", ERR, 1'b0);
    check("rst_rdata", RDATA, 16'h0000);
    check("rst_hsel", HSEL, 1'b0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", HWRITE, 1'b0);
    check("rst_hwdata", HWDATA, 32'h0);
    HRESETn = 1'b1;
    cyc();

    // Both requesters always asking: grants alternate 0,1,0,1 starting with 0.
    REQ = 2'b11; HRDATA = 32'hDEAD_0042;
    for (int k = 0; k < 13; k++) begin
      if (k == 12) REQ = 2'b00;
      mid();
      check($sformatf("rr_gnt%0d", k), GNT, rr_gnt[k]);
      check($sformatf("rr_done%0d", k), DONE, rr_done[k]);
      cyc();
    end
    check("rr_rdata", RDATA, 16'h0042);

    //   id  we dir wdata     waits hrdata        par exp_hwdata     exp_rd   err
    xfer(0, 1, 0, 16'hA5C3, 0,  32'h0000_0000, 0, 32'h0000_A5C3, 16'h0042, 0);
    xfer(1, 1, 1, 16'h0001, 0,  32'h0000_0000, 0, 32'hFFFF_FFFF, 16'h0042, 0);
    xfer(1, 1, 1, 16'hFFFE, 0,  32'h0000_0000, 0, 32'h0000_0000, 16'h0042, 0);
    xfer(1, 0, 0, 16'h0000, 0,  32'h0000_1234, 0, 32'h0000_0000, 16'h1234, 0);
    xfer(0, 0, 1, 16'h0000, 3,  32'hFFFF_5678, 0, 32'h0000_0000, 16'h5678, 0);
    xfer(0, 0, 0, 16'h0000, 16, 32'h0000_ABCD, 0, 32'h0000_0000, 16'h5678, 1);
    xfer(1, 0, 0, 16'h0000, 15, 32'h0000_9999, 0, 32'h0000_0000, 16'h9999, 0);
`ifdef AHB_GPIO_ARB_PARITY_EN
    xfer(0, 0, 0, 16'h0000, 0,  32'h0000_7777, 1, 32'h0000_0000, 16'h7777, 1);
`else
    xfer(0, 0, 0, 16'h0000, 0,  32'h0000_7777, 1, 32'h0000_0000, 16'h7777, 0);
`endif

    // Reset during a data-phase wait: everything back to reset values, no DONE.
    REQ = 2'b01; WE = 2'b11; DIRSEL = 2'b00; WDATA0 = 16'h1111;
    cyc();
    mid();
    check("rm_gnt", GNT, 2'b01);
    cyc();
    REQ = 2'b00; HREADYOUT = 1'b0;
    mid();
    check("rm_hwdata", HWDATA, 32'h0000_1111);
    #1 HRESETn = 1'b0;
    #1;
    check("rm_rst_hwdata", HWDATA, 32'h0);
    check("rm_rst_rdata", RDATA, 16'h0);
    check("rm_rst_done", DONE, 2'b00);
    check("rm_rst_hsel", HSEL, 1'b0);
    @(posedge HCLK);
    mid();
    HRESETn = 1'b1;
    HREADYOUT = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      mid();
      check("rm_no_done", DONE, 2'b00);
    end

    // Tie after reset must go to requester 0 again.
    cyc();
    REQ = 2'b11; WE = 2'b00;
    cyc();
    mid();
    check("rm_tie_gnt", GNT, 2'b01);
    cyc();
    REQ = 2'b00;
    cyc();
    mid();
    check("rm_tie_done", DONE, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_arbiter.md
# ahb_gpio_arbiter

Two-port AHB-Lite master front-end that shares the AHB GPIO slave between two local requesters. Each requester issues single read/write commands to the GPIO data or direction register; the arbiter grants round-robin, runs one AHB transfer at a time (address phase, then data phase with wait states), and returns read data, completion and error status. It sits between the GPIO-using control logic and the AHB GPIO slave's bus port.

## Interface
Parameters:
- GPIO_BASE, 32'h0000_0000, base address of the GPIO slave; data register at +0x00, direction register at +0x04.
- TIMEOUT, 16, data-phase wait-state limit in cycles (2..255).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- REQ  in  2  per-requester command request; command fields stable while REQ high until GNT.
- WE  in  2  per-requester write enable (1 = write, 0 = read).
- DIRSEL  in  2  per-requester register select (0 = data, 1 = direction).
- WDATA0  in  16  requester 0 write data.
- WDATA1  in  16  requester 1 write data.
- GNT  out  2  one-hot, one-cycle pulse in the address-phase cycle of the granted requester.
- DONE  out  2  one-hot, one-cycle pulse when the transfer of that requester finishes.
- RDATA  out  16  read data of the last completed read; held until the next read completes.
- ERR  out  1  error status for the transfer signalled by DONE; valid only while DONE is high.
- HSEL, HTRANS[1:0], HADDR[31:0], HWRITE, HWDATA[31:0], HREADY  out  AHB master signals to the GPIO slave.
- HREADYOUT  in  1, HRDATA  in  32, PARITYERR  in  1  slave responses.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any REQ bit is high, arbitrate and go to ADDR next cycle; otherwise stay.
- Arbitration: single request wins; both requests grant the requester not granted last. Last-grant register resets to 1, so requester 0 wins the first tie.
- ADDR (one cycle): HSEL=1, HTRANS=2'b10 (NONSEQ), HADDR=GPIO_BASE + (DIRSEL ? 4 : 0), HWRITE=WE of winner, GNT pulse. Command latched into internal registers; next state DATA.
- DATA: HSEL=0, HTRANS=IDLE; HWDATA driven from latched command: data write = {16'h0, WDATA}; direction write = WDATA[0] ? 32'hFFFF_FFFF : 32'h0. Stay while HREADYOUT=0, counting wait cycles.
- Completion: first DATA cycle with HREADYOUT=1 -> register HRDATA[15:0] into RDATA (reads only), pulse DONE next cycle, return to IDLE.
- Timeout: wait counter reaches TIMEOUT with HREADYOUT still 0 -> abandon, DONE with ERR=1, RDATA unchanged, back to IDLE.
- HREADY output = HREADYOUT (single slave).
- Requester keeping REQ high after DONE gets a new transfer, subject to round-robin.

## Timing
- Reset values: FSM IDLE, HSEL=0, HTRANS=0, HADDR=0, HWRITE=0, HWDATA=0, GNT=0, DONE=0, ERR=0, RDATA=0, wait counter 0, last-grant=1.
- Minimum latency: REQ high in cycle 0 -> GNT cycle 1 -> data phase cycle 2 -> DONE cycle 3 (zero wait states). Each wait state adds one cycle.
- Throughput: at most one transfer per 3 cycles; no address/data pipelining.
- REQ deasserted before GNT: request is dropped; if seen in IDLE only, no transfer started.
- Reset mid-transfer: all outputs return to reset values immediately; no DONE issued for the aborted transfer.
- Wait counter width 8 bits; cleared on entry to DATA.

## Configuration
- AHB_GPIO_ARB_PARITY_EN defined: PARITYERR sampled in the completing DATA cycle of a read; if 1, DONE carries ERR=1 and RDATA is still updated.
- Undefined: PARITYERR ignored; ERR is set only by timeout.

## Test plan
- Requester 0 writes data 16'hA5C3, HREADYOUT=1 -> GNT[0] cycle 1, HADDR=GPIO_BASE, HWRITE=1, HWDATA=32'h0000_A5C3 cycle 2, DONE[0] cycle 3, ERR=0.
- Requester 1 direction write WDATA=16'h0001 -> HADDR=GPIO_BASE+4, HWDATA=32'hFFFF_FFFF; then read with HRDATA=32'h0000_1234 -> RDATA=16'h1234 with DONE[1].
- Both REQ high continuously after reset -> grants alternate 0,1,0,1; DONE order matches.
- HREADYOUT held 0 for 3 cycles then 1 -> DONE delayed exactly 3 cycles; HREADYOUT held 0 for TIMEOUT=16 -> DONE with ERR=1, RDATA unchanged.
- Read with PARITYERR=1 at completion -> ERR=1 with AHB_GPIO_ARB_PARITY_EN, ERR=0 without.
- HRESETn low during DATA wait -> outputs at reset values, no DONE; next REQ starts from IDLE with requester 0 priority.
